// File: rtl/snn_ctrl.sv
// -----------------------------------------------------------------------------
// snn_ctrl - top-level sequencer for the SNN digit classifier.
//
// Receives a binary image as a stream of bytes. Each byte is unpacked LSB first
// into the single-bit input-unit RAM at ascending pixel addresses. Once
// NUM_PIXELS pixels are stored, snn_core is started and given the RAM read
// port. The classified digit is latched and handed to the transmitter, and
// the controller then waits for the next image.
//
// Configuration macro:
//   SNN_CTRL_ASCII_EN  defined   -> tx_data = {4'h3, digit} (ASCII '0'..'9')
//                      undefined -> tx_data = {4'h0, digit} (raw binary)
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   rx_rdy, rx_data   one-cycle byte strobe and pixel byte (bit 0 = lowest addr)
//   core_start        one-cycle start pulse to snn_core (registered)
//   core_done         snn_core completion strobe (honoured only while waiting)
//   core_digit        snn_core classification result
//   core_addr         snn_core read address, routed to ram_addr while it runs
//   ram_addr/we/wdata input-unit RAM port (combinational mux on state)
//   tx_start, tx_data one-cycle transmit request and registered byte
//   tx_busy           transmitter busy, holds the report back
//   busy              high whenever the controller is not ready for a byte
//   overrun           sticky: a byte arrived while not ready; cleared by reset
// -----------------------------------------------------------------------------
module snn_ctrl #(
   parameter int NUM_PIXELS = 784,
   parameter int ADDR_W     = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_rdy,
   input  logic [7:0]        rx_data,
   output logic              core_start,
   input  logic              core_done,
   input  logic [3:0]        core_digit,
   input  logic [ADDR_W-1:0] core_addr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic              ram_wdata,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   output logic              busy,
   output logic              overrun
);

   typedef enum logic [2:0] {
      ST_LOAD   = 3'd0,
      ST_UNPACK = 3'd1,
      ST_START  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_REPORT = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);
   localparam logic [ADDR_W-1:0] PIX_ONE  = ADDR_W'(1);

`ifdef SNN_CTRL_ASCII_EN
   localparam logic [3:0] TX_HI = 4'h3;
`else
   localparam logic [3:0] TX_HI = 4'h0;
`endif

   state_t              state_r;
   state_t              state_nxt_s;
   logic [7:0]          byte_r;
   logic [2:0]          bit_cnt_r;
   logic [ADDR_W-1:0]   pix_cnt_r;
   logic [3:0]          digit_r;
   logic                core_start_r;
   logic                tx_start_r;
   logic [7:0]          tx_data_r;
   logic                busy_r;
   logic                overrun_r;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_LOAD;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_LOAD: begin
            if (rx_rdy) begin
               state_nxt_s = ST_UNPACK;
            end else begin
               state_nxt_s = ST_LOAD;
            end
         end
         ST_UNPACK: begin
            // The pixel written this cycle is pix_cnt_r; after bit 7 the
            // image is complete exactly when that pixel was the last one.
            if (bit_cnt_r == 3'd7) begin
               if (pix_cnt_r == LAST_PIX) begin
                  state_nxt_s = ST_START;
               end else begin
                  state_nxt_s = ST_LOAD;
               end
            end else begin
               state_nxt_s = ST_UNPACK;
            end
         end
         ST_START: begin
            state_nxt_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (core_done) begin
               state_nxt_s = ST_REPORT;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_REPORT: begin
            if (!tx_busy) begin
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_REPORT;
            end
         end
         default: begin
            state_nxt_s = ST_LOAD;
         end
      endcase
   end

   // Byte capture, bit/pixel counters and digit latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_r    <= 8'h00;
         bit_cnt_r <= 3'd0;
         pix_cnt_r <= '0;
         digit_r   <= 4'h0;
      end else begin
         case (state_r)
            ST_LOAD: begin
               if (rx_rdy) begin
                  byte_r    <= rx_data;
                  bit_cnt_r <= 3'd0;
               end
            end
            ST_UNPACK: begin
               pix_cnt_r <= pix_cnt_r + PIX_ONE;
               bit_cnt_r <= bit_cnt_r + 3'd1;
            end
            ST_WAIT: begin
               if (core_done) begin
                  digit_r <= core_digit;
               end
            end
            ST_REPORT: begin
               if (!tx_busy) begin
                  pix_cnt_r <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Registered control outputs; core_start and busy are derived from the
   // next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_start_r <= 1'b0;
         tx_start_r   <= 1'b0;
         tx_data_r    <= 8'h00;
         busy_r       <= 1'b0;
         overrun_r    <= 1'b0;
      end else begin
         core_start_r <= (state_nxt_s == ST_START);
         busy_r       <= (state_nxt_s != ST_LOAD);
         tx_start_r   <= (state_r == ST_REPORT) && !tx_busy;
         if ((state_r == ST_REPORT) && !tx_busy) begin
            tx_data_r <= {TX_HI, digit_r};
         end
         if (rx_rdy && (state_r != ST_LOAD)) begin
            overrun_r <= 1'b1;
         end
      end
   end

   // RAM port ownership: the controller owns it while loading, the core
   // owns the read address from start until the report is sent.
   always_comb begin
      ram_addr  = pix_cnt_r;
      ram_we    = 1'b0;
      ram_wdata = 1'b0;
      case (state_r)
         ST_LOAD: begin
            ram_addr = pix_cnt_r;
         end
         ST_UNPACK: begin
            ram_addr  = pix_cnt_r;
            ram_we    = 1'b1;
            ram_wdata = byte_r[bit_cnt_r];
         end
         ST_START, ST_WAIT, ST_REPORT: begin
            ram_addr = core_addr;
         end
         default: begin
            ram_addr = pix_cnt_r;
         end
      endcase
   end

   assign core_start = core_start_r;
   assign tx_start   = tx_start_r;
   assign tx_data    = tx_data_r;
   assign busy       = busy_r;
   assign overrun    = overrun_r;

endmodule

// File: tb/tb_snn_ctrl.sv
module tb_snn_ctrl;

   localparam int NUM_PIXELS = 784;
   localparam int ADDR_W     = 10;

`ifdef SNN_CTRL_ASCII_EN
   localparam logic [3:0] HI     = 4'h3;
   localparam logic [7:0] EXP_7  = 8'h37;
   localparam logic [7:0] EXP_12 = 8'h3C;
   localparam logic [7:0] EXP_3  = 8'h33;
`else
   localparam logic [3:0] HI     = 4'h0;
   localparam logic [7:0] EXP_7  = 8'h07;
   localparam logic [7:0] EXP_12 = 8'h0C;
   localparam logic [7:0] EXP_3  = 8'h03;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              rx_rdy;
   logic [7:0]        rx_data;
   logic              core_start;
   logic              core_done;
   logic [3:0]        core_digit;
   logic [ADDR_W-1:0] core_addr;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic              ram_wdata;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              tx_busy;
   logic              busy;
   logic              overrun;

   snn_ctrl #(.NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
      .core_start(core_start), .core_done(core_done), .core_digit(core_digit),
      .core_addr(core_addr), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(tx_busy), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Tracks how many pixels are stored, how many pixel writes of the current
   // byte are still owed, and whether the core or the report is outstanding.
   int         m_bits_left = 0;
   int         m_pix       = 0;
   int         m_core      = 0;   // 0 none, 1 start cycle, 2 waiting for done
   bit         m_rep       = 1'b0;
   logic [7:0] m_byte      = 8'h00;
   logic [3:0] m_digit     = 4'h0;
   bit         e_we = 1'b0, e_wdata = 1'b0, e_core_start = 1'b0, e_tx_start = 1'b0;
   bit         e_busy = 1'b0, e_over = 1'b0;
   int         e_addr = 0;
   logic [7:0] e_tx_data = 8'h00;
   int         cyc = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_bits_left = 0; m_pix = 0; m_core = 0; m_rep = 1'b0;
         m_byte = 8'h00; m_digit = 4'h0;
         e_we = 1'b0; e_wdata = 1'b0; e_core_start = 1'b0; e_tx_start = 1'b0;
         e_busy = 1'b0; e_over = 1'b0; e_addr = 0; e_tx_data = 8'h00;
      end else begin
         cyc++;
         e_core_start = 1'b0;
         e_tx_start   = 1'b0;
         if (rx_rdy && e_busy) e_over = 1'b1;
         if (m_bits_left > 0) begin
            m_pix++;
            m_bits_left--;
            if (m_bits_left == 0 && m_pix == NUM_PIXELS) begin
               m_core = 1;
               e_core_start = 1'b1;
            end
         end else if (m_core == 1) begin
            m_core = 2;
         end else if (m_core == 2) begin
            if (core_done) begin
               m_digit = core_digit;
               m_core = 0;
               m_rep = 1'b1;
            end
         end else if (m_rep) begin
            if (!tx_busy) begin
               e_tx_start = 1'b1;
               e_tx_data = {HI, m_digit};
               m_pix = 0;
               m_rep = 1'b0;
            end
         end else if (rx_rdy) begin
            m_byte = rx_data;
            m_bits_left = 8;
         end
         e_we   = (m_bits_left > 0);
         e_addr = m_pix;
         if (m_bits_left > 0) begin
            int idx;
            idx = 8 - m_bits_left;
            e_wdata = m_byte[idx[2:0]];
         end else begin
            e_wdata = 1'b0;
         end
         e_busy = (m_bits_left > 0) || (m_core != 0) || m_rep;
      end
   end

   // ---------------- compare process + monitor ----------------
   logic shadow [0:1023];
   int   n_cs = 0, n_tx = 0, cs_cyc = 0, last_wr_cyc = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_ram_we", ram_we, 1'b0);
         chk("rst_ram_wdata", ram_wdata, 1'b0);
         chk("rst_ram_addr", ram_addr, 0);
         chk("rst_core_start", core_start, 1'b0);
         chk("rst_tx_start", tx_start, 1'b0);
         chk("rst_tx_data", tx_data, 8'h00);
         chk("rst_busy", busy, 1'b0);
         chk("rst_overrun", overrun, 1'b0);
      end else begin
         chk("ram_we", ram_we, e_we);
         if (e_we) begin
            chk("ram_addr_wr", ram_addr, e_addr);
            chk("ram_wdata", ram_wdata, e_wdata);
         end else if (m_core != 0 || m_rep) begin
            chk("ram_addr_core", ram_addr, core_addr);
            chk("ram_wdata_core", ram_wdata, 1'b0);
         end else begin
            chk("ram_addr_load", ram_addr, e_addr);
         end
         chk("core_start", core_start, e_core_start);
         chk("tx_start", tx_start, e_tx_start);
         chk("tx_data", tx_data, e_tx_data);
         chk("busy", busy, e_busy);
         chk("overrun", overrun, e_over);
         if (ram_we) begin
            shadow[ram_addr] = ram_wdata;
            if (ram_addr == ADDR_W'(NUM_PIXELS - 1)) last_wr_cyc = cyc;
         end
         if (core_start) begin
            n_cs++;
            cs_cyc = cyc;
         end
         if (tx_start) n_tx++;
      end
   end

   function automatic logic [7:0] shadow_byte(input int base);
      logic [7:0] b;
      for (int k = 0; k < 8; k++) b[k] = shadow[base + k];
      return b;
   endfunction

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_rdy  = 1'b1;
      rx_data = b;
      tick(1);
      rx_rdy  = 1'b0;
      tick(gap - 1);
   endtask

   initial begin
      rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; core_done = 1'b0;
      core_digit = 4'h0; core_addr = '0; tx_busy = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(20);
      chk("idle_busy", busy, 1'b0);
      chk("idle_ram_addr", ram_addr, 0);

      // Image 1: 98 x A5, spaced 12 cycles.
      for (int i = 0; i < 98; i++) send_byte(8'hA5, 12);
      chk("img1_cs_count", n_cs, 1);
      chk("img1_cs_after_783", cs_cyc - last_wr_cyc, 1);
      chk("img1_first_byte", shadow_byte(0), 8'hA5);
      chk("img1_last_byte", shadow_byte(776), 8'hA5);
      core_addr = 10'd300;
      tick(5);
      chk("wait_ram_addr", ram_addr, 10'd300);
      chk("wait_busy", busy, 1'b1);
      core_done = 1'b1; core_digit = 4'd7;
      tick(1);
      core_done = 1'b0; core_digit = 4'd0;
      tick(3);
      chk("img1_tx_count", n_tx, 1);
      chk("img1_tx_data", tx_data, EXP_7);
      chk("img1_back_to_load", busy, 1'b0);

      // Stray core_done while idle must be ignored.
      core_done = 1'b1; tick(1); core_done = 1'b0; tick(2);
      chk("stray_done_busy", busy, 1'b0);

      // Image 2: overrun during first UNPACK, then backpressure on report.
      rx_rdy = 1'b1; rx_data = 8'hA5; tick(1); rx_rdy = 1'b0;
      tick(3);
      rx_rdy = 1'b1; rx_data = 8'hFF; tick(1); rx_rdy = 1'b0;
      tick(1);
      chk("overrun_set", overrun, 1'b1);
      tick(6);
      for (int i = 1; i < 98; i++) send_byte(8'h3C, 12);
      chk("img2_cs_count", n_cs, 2);
      chk("img2_first_byte", shadow_byte(0), 8'hA5);
      chk("img2_second_byte", shadow_byte(8), 8'h3C);
      tx_busy = 1'b1;
      core_done = 1'b1; core_digit = 4'd12;
      tick(1);
      core_done = 1'b0;
      tick(50);
      chk("bp_no_tx", n_tx, 1);
      chk("bp_busy", busy, 1'b1);
      tx_busy = 1'b0;
      tick(1);
      chk("bp_tx_pulse", tx_start, 1'b1);
      tick(3);
      chk("bp_tx_count", n_tx, 2);
      chk("bp_tx_data", tx_data, EXP_12);
      chk("overrun_sticky", overrun, 1'b1);

      // Reset in the middle of the 51st byte (pix_cnt ~400), full-rate stream.
      for (int i = 0; i < 50; i++) send_byte(8'hFF, 9);
      rx_rdy = 1'b1; rx_data = 8'h00; tick(1); rx_rdy = 1'b0;
      tick(2);
      rst_n = 1'b0;
      tick(2);
      chk("mid_rst_overrun", overrun, 1'b0);
      chk("mid_rst_tx_data", tx_data, 8'h00);
      rst_n = 1'b1;
      tick(2);
      for (int i = 0; i < 98; i++) send_byte(8'(i * 37 + 1), 9);
      tick(3);
      chk("img3_cs_count", n_cs, 3);
      chk("img3_cs_after_783", cs_cyc - last_wr_cyc, 1);
      chk("img3_first_byte", shadow_byte(0), 8'h01);
      chk("img3_last_byte", shadow_byte(776), 8'h06);
      core_done = 1'b1; core_digit = 4'd3;
      tick(1);
      core_done = 1'b0;
      tick(3);
      chk("img3_tx_count", n_tx, 3);
      chk("img3_tx_data", tx_data, EXP_3);
      chk("img3_overrun", overrun, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
